// File: rtl/comp_pkg.sv
// comp_pkg: shared definitions for the serial N-bit magnitude comparator.
//   state_e        - FSM state encoding (IDLE, COMPARE)
//   slices_width() - width of the "slices" result port for a given slice count
//   cfg_ok()       - legality check of the WIDTH/SLICE pair, evaluated at elaboration
package comp_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_e;

    // Enough bits to hold the value NSLICE itself (count runs 1..NSLICE).
    function automatic int slices_width(input int nslice);
        return $clog2(nslice) + 1;
    endfunction

    // Operands must split into whole slices and be at least two bits wide.
    function automatic bit cfg_ok(input int width, input int slice);
        return (slice >= 1) && (width >= 2) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/comp_slice.sv
// comp_slice: combinational unsigned magnitude comparator for one W-bit slice.
//   a, b - slice operands
//   gt   - a > b, lt - a < b, eq - a == b (exactly one is high)
module comp_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt,
    output logic         eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comp_serial_nbit.sv
// comp_serial_nbit: multi-cycle magnitude comparator. Walks the operands one
// SLICE-bit slice per cycle from the MSB end and stops at the first slice that
// differs, so a wide compare never sits on one combinational path.
//   clk, rst          - clock, synchronous active-high reset
//   start             - request, accepted only while idle
//   is_signed         - 1: two's-complement compare, 0: unsigned (latched with start)
//   a, b              - WIDTH-bit operands (latched with start)
//   busy              - compare in progress
//   done              - one-cycle pulse, result valid
//   gt, lt, eq        - registered result, held until the next done
//   slices            - slices examined for the last result (1..NSLICE)
module comp_serial_nbit
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   is_signed,
    input  logic [WIDTH-1:0]                       a,
    input  logic [WIDTH-1:0]                       b,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   gt,
    output logic                                   lt,
    output logic                                   eq,
    output logic [slices_width(WIDTH/SLICE)-1:0]   slices
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int SW     = slices_width(NSLICE);
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IW-1:0]    TOP_IDX    = IW'(NSLICE - 1);
    localparam logic [SW-1:0]    NSLICE_CNT = SW'(NSLICE);
    localparam logic [SLICE-1:0] MSB_MASK   = SLICE'(1) << (SLICE - 1);

    generate
        if (!cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
            $fatal(1, "comp_serial_nbit: WIDTH must be >= 2 and a multiple of SLICE >= 1");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic [SW-1:0]    slices_q, slices_d;

    logic             top_flip_s;
    logic [SLICE-1:0] a_sl_s, b_sl_s;
    logic             sl_gt_s, sl_lt_s, sl_eq_s;

    // Select the current slice; in signed mode the top slice gets its MSB
    // inverted, which maps two's-complement order onto unsigned order.
    always_comb begin
        top_flip_s = sgn_q & (idx_q == TOP_IDX);
        a_sl_s     = a_q[int'(idx_q) * SLICE +: SLICE] ^ (top_flip_s ? MSB_MASK : {SLICE{1'b0}});
        b_sl_s     = b_q[int'(idx_q) * SLICE +: SLICE] ^ (top_flip_s ? MSB_MASK : {SLICE{1'b0}});
    end

    comp_slice #(
        .W (SLICE)
    ) u_slice (
        .a  (a_sl_s),
        .b  (b_sl_s),
        .gt (sl_gt_s),
        .lt (sl_lt_s),
        .eq (sl_eq_s)
    );

    // Next-state and output-register logic of the compare FSM.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        slices_d = slices_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    idx_d   = TOP_IDX;
                    cnt_d   = SW'(1);
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (!sl_eq_s) begin
                    // First differing slice decides the whole compare.
                    gt_d     = sl_gt_s;
                    lt_d     = sl_lt_s;
                    eq_d     = 1'b0;
                    slices_d = cnt_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (idx_q == {IW{1'b0}}) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b1;
                    slices_d = NSLICE_CNT;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    idx_d    = idx_q - IW'(1);
                    cnt_d    = cnt_q + SW'(1);
                    state_d  = COMPARE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            sgn_q    <= 1'b0;
            idx_q    <= {IW{1'b0}};
            cnt_q    <= {SW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            slices_q <= {SW{1'b0}};
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            slices_q <= slices_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign eq     = eq_q;
    assign slices = slices_q;

endmodule

// File: tb/tb_comp_serial_nbit.sv
// Self-checking bench for comp_serial_nbit (WIDTH=16, SLICE=4): directed cases
// followed by a randomised sweep, all checked against a behavioural compare.
module tb_comp_serial_nbit;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = 4;
    localparam logic [15:0] SMASK = 16'h000F;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        gt;
    logic        lt;
    logic        eq;
    logic [2:0]  slices;

    int n_cmp = 0;
    int n_err = 0;

    // Expected value of the held result registers (last registered result).
    logic e_gt = 1'b0;
    logic e_lt = 1'b0;
    logic e_eq = 1'b0;
    int   e_sl = 0;

    comp_serial_nbit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .slices    (slices)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain numeric compare; slices = 1 + leading equal slices.
    function automatic void ref_cmp(input logic [15:0] ra, input logic [15:0] rb, input logic rs,
                                    output logic g, output logic l, output logic e, output int sl);
        bit found;
        if (rs) begin
            g = ($signed(ra) > $signed(rb));
            l = ($signed(ra) < $signed(rb));
        end else begin
            g = (ra > rb);
            l = (ra < rb);
        end
        e = (ra == rb);
        sl = NSLICE;
        found = 1'b0;
        for (int i = NSLICE - 1; i >= 0; i--) begin
            if (!found && (((ra >> (i * SLICE)) & SMASK) != ((rb >> (i * SLICE)) & SMASK))) begin
                sl = NSLICE - i;
                found = 1'b1;
            end
        end
    endfunction

    task automatic check_zero(input string tag);
        chk_val({tag, "_busy"}, busy, 1'b0);
        chk_val({tag, "_done"}, done, 1'b0);
        chk_val({tag, "_gt"}, gt, 1'b0);
        chk_val({tag, "_lt"}, lt, 1'b0);
        chk_val({tag, "_eq"}, eq, 1'b0);
        chk_val({tag, "_slices"}, slices, 3'd0);
    endtask

    // Present a request for exactly one accepting edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
        start = 1'b1;
        a = ta;
        b = tb_;
        is_signed = ts;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_val("busy_after_start", busy, 1'b1);
    endtask

    // Wait (bounded) for done; while busy the old result must be held.
    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= NSLICE + 2; i++) begin
            if (!got) begin
                @(posedge clk);
                #1;
                if (done) begin
                    lat = i;
                    got = 1'b1;
                end else begin
                    chk_val("busy_hold", busy, 1'b1);
                    chk_val("gt_hold", gt, e_gt);
                    chk_val("lt_hold", lt, e_lt);
                    chk_val("eq_hold", eq, e_eq);
                    chk_val("slices_hold", slices, e_sl);
                end
            end
        end
        if (!got) chk_val("done_timeout", done, 1'b1);
    endtask

    task automatic finish_cmp(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                              input string tag, input bit idle_chk);
        int lat;
        bit got;
        logic rg, rl, re;
        int rs_n;
        wait_done(lat, got);
        ref_cmp(ta, tb_, ts, rg, rl, re, rs_n);
        e_gt = rg;
        e_lt = rl;
        e_eq = re;
        e_sl = rs_n;
        if (got) begin
            chk_val({tag, "_gt"}, gt, rg);
            chk_val({tag, "_lt"}, lt, rl);
            chk_val({tag, "_eq"}, eq, re);
            chk_val({tag, "_slices"}, slices, rs_n);
            chk_val({tag, "_latency"}, lat, rs_n);
            chk_val({tag, "_busy_at_done"}, busy, 1'b0);
        end
        if (idle_chk) begin
            start = 1'b0;
            @(posedge clk);
            #1;
            chk_val({tag, "_done_pulse"}, done, 1'b0);
            chk_val({tag, "_idle"}, busy, 1'b0);
        end
    endtask

    task automatic do_cmp(input logic [15:0] ta, input logic [15:0] tb_, input logic ts, input string tag);
        @(negedge clk);
        issue(ta, tb_, ts);
        finish_cmp(ta, tb_, ts, tag, 1'b1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        do_cmp(16'hA000, 16'h5000, 1'b0, "early_gt");
        do_cmp(16'h1234, 16'h1234, 1'b0, "full_eq");
        do_cmp(16'h1234, 16'h1235, 1'b0, "full_lt");
        do_cmp(16'hFFFF, 16'h0001, 1'b0, "unsigned_ffff");
        do_cmp(16'hFFFF, 16'h0001, 1'b1, "signed_ffff");
        do_cmp(16'h8000, 16'h7FFF, 1'b1, "signed_min");

        // start held high (with new operands) all through a busy compare
        @(negedge clk);
        issue(16'h1234, 16'h1235, 1'b0);
        start = 1'b1;
        a = 16'h0000;
        b = 16'h0000;
        finish_cmp(16'h1234, 16'h1235, 1'b0, "busy_ignore", 1'b1);

        // back-to-back: start raised in the done cycle
        @(negedge clk);
        issue(16'h1234, 16'h1234, 1'b0);
        finish_cmp(16'h1234, 16'h1234, 1'b0, "b2b_first", 1'b0);
        chk_val("b2b_done_seen", done, 1'b1);
        issue(16'h0003, 16'h0007, 1'b0);
        finish_cmp(16'h0003, 16'h0007, 1'b0, "b2b_second", 1'b1);

        // reset in the middle of a compare
        @(negedge clk);
        issue(16'h8880, 16'h8881, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midop_reset");
        e_gt = 1'b0;
        e_lt = 1'b0;
        e_eq = 1'b0;
        e_sl = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk_val("post_reset_no_done", done, 1'b0);
        end
        do_cmp(16'h8880, 16'h8881, 1'b0, "after_reset");

        // randomised sweep, biased towards long equal prefixes
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                2: rb = ra ^ 16'h8000;
                default: rb = 16'($urandom);
            endcase
            do_cmp(ra, rb, rs, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/comp_serial_nbit.md
Name: comp_serial_nbit

Overview:
- Parametrised, multi-cycle magnitude comparator. Successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands one SLICE-bit slice per cycle, MSB slice first.
- Stops early at the first differing slice, supports signed or unsigned mode, and reports results through a start/busy/done handshake.
- Sits in the datapath where wide compares must not sit on the critical path.

Parameters:
- WIDTH, 16, operand width in bits; must be ≥ 2 and a multiple of SLICE.
- SLICE, 4, bits compared per cycle; must be ≥ 1.
- NSLICE, WIDTH/SLICE, derived (localparam), number of slices.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse; result valid.
- gt  output  1  A > B.
- lt  output  1  A < B.
- eq  output  1  A == B.
- slices  output  $clog2(NSLICE)+1  number of slices examined for the last result (1..NSLICE).

Behaviour:
- Reset: state IDLE, busy=0, done=0, gt=0, lt=0, eq=0, slices=0, internal operand and index registers cleared.
- Interface: one clock domain, clk; reset rst is synchronous and active-high.
- Reset mid-operation: aborts the compare; no done pulse; outputs return to reset values on the next edge.
- States: IDLE, COMPARE.
- IDLE:
  - start=1 at an edge latches a, b, is_signed; sets idx=NSLICE-1 and cnt=1; goes to COMPARE; busy=1 from that edge.
  - start=0: stays in IDLE.
- COMPARE, one slice per cycle: slice idx of A and B goes to comp_slice.
- Signed mode, top slice only: the MSB of both A and B is inverted before comparing. Lower slices are always compared unsigned.
- Slice differs: at that edge, register gt/lt from the slice result, set eq=0, slices=cnt, done=1, busy=0; return to IDLE.
- Slice equal and idx==0: at that edge, set eq=1, gt=0, lt=0, slices=NSLICE, done=1, busy=0; return to IDLE.
- Slice equal and idx>0: decrement idx, increment cnt, stay in COMPARE.
- Latency: done rises k cycles after the start-accepting edge, where k = slices examined. Range is 1 to NSLICE.
- done is high for exactly one cycle.
- gt/lt/eq/slices hold their value until the next result is registered. They stay unchanged while busy.
- Exactly one of gt/lt/eq is high after the first done. All three are 0 before the first done.
- start while busy: ignored, with no queueing. Operand changes while busy do not affect the result.
- start high in the done cycle: accepted, because the FSM is already in IDLE. Back-to-back compares with zero idle cycles are legal.
- SLICE==WIDTH: degenerates to a fixed 1-cycle latency.

Decomposition:
- Package comp_pkg:
  - state enum (IDLE, COMPARE);
  - function computing the slices-port width;
  - elaboration-time checks: WIDTH % SLICE == 0 and SLICE ≥ 1 (fatal on failure).
- Sub-module comp_slice: combinational, parameter W=SLICE; inputs a, b; outputs gt, lt, eq. This is the existing comparator form, generalised in width.
- Top module: FSM, operand registers, slice mux, sign-flip logic and output registers.

Test Plan (WIDTH=16, SLICE=4):
- Early decision, unsigned: a=0xA000, b=0x5000, is_signed=0 → done 1 cycle after start; gt=1, lt=0, eq=0, slices=1.
- Full scan, equal: a=b=0x1234 → done 4 cycles after start; eq=1, slices=4. Then a=0x1234, b=0x1235 → lt=1, slices=4.
- Signed vs unsigned, a=0xFFFF, b=0x0001:
  - is_signed=0 → gt=1;
  - is_signed=1 (−1 vs 1) → lt=1;
  - both cases slices=1.
- Handshake:
  - start pulsed while busy (a=0, b=0 applied mid-compare) is ignored; the original result stands.
  - start held high in the done cycle with a=3, b=7 → second compare accepted immediately; lt=1 after 4 more cycles (slices=4).
- Reset mid-op: start a=0x8880, b=0x8881, assert rst on cycle 2 → no done pulse, gt/lt/eq/slices=0, busy=0; normal operation resumes after rst falls.
- Randomised sweep: 1000 random a/b/is_signed → results match a behavioural reference compare; slices equals 1 + the count of equal leading slices.
